mem_port_arbiter: RTL and testbench

//  Shares one unified, variable-latency memory bus port between two requesters: instruction fetch (IF, read-only word)
//  and data access (MEM stage, load/store with FUNC3 sizing). Runs a per-transaction grant FSM with data priority
//  and a fetch anti-starvation limit. Requesters hold REQ high until READY; the pipeline stalls on REQ && !READY.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_bus_watchdog.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter:
//     - arb_state_t : 2-bit grant FSM state encoding
//     - FUNC3_LW    : RV32 word access size, always used for instruction fetch
//     - mem_wins()  : data-side grant decision used in the IDLE state
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_IF  = 2'b01,
        ST_GNT_MEM = 2'b10,
        ST_RESP    = 2'b11
    } arb_state_t;

    localparam logic [2:0] FUNC3_LW = 3'b010;

    // Data access has priority unless a fetch is pending and the data side
    // has already used up its burst allowance.
    function automatic logic mem_wins(input logic mem_req,
                                      input logic if_req,
                                      input logic burst_full);
        return mem_req && !(if_req && burst_full);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// -----------------------------------------------------------------------------
// bus_watchdog
//   Counts cycles spent waiting for a bus acknowledge and flags expiry once the
//   wait has lasted TIMEOUT_CYCLES cycles. The counter clears whenever run is
//   low, so each grant starts a fresh wait.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  synchronous reset, active-low
//   run    in  1  high while a grant is waiting on the bus
//   expire out 1  high in the last allowed wait cycle (combinational)
// -----------------------------------------------------------------------------
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // count_q holds the number of wait cycles already elapsed, so the flag
    // rises during the TIMEOUT_CYCLES-th cycle of the grant.
    assign expire = run && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = '0;
        if (run) begin
            count_d = expire ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single variable-latency memory bus between instruction fetch (IF)
//   and data access (MEM). One transaction at a time goes through
//   IDLE -> GNT_x -> RESP -> IDLE. Data access has priority, but after
//   MAX_DATA_BURST consecutive data grants with a fetch pending, the fetch is
//   served next. All outputs are registered.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : a bus_watchdog aborts a grant after TIMEOUT_CYCLES cycles
//                 without BUS_ACK; READY is issued with RDATA=0 and BUS_ERR=1.
//     undefined : grants wait for BUS_ACK indefinitely, BUS_ERR stays 0.
//
// Ports:
//   CLK, RST                 clock, synchronous active-low reset
//   IF_REQ/IF_ADDR           fetch request (held until IF_READY)
//   IF_RDATA/IF_READY        fetch word and one-cycle completion pulse
//   MEM_REQ/WE/ADDR/WDATA/FUNC3  data request (held until MEM_READY)
//   MEM_RDATA/MEM_READY      load data and one-cycle completion pulse
//   BUS_REQ/WE/ADDR/WDATA/FUNC3  bus request, held until BUS_ACK
//   BUS_ACK/BUS_RDATA        bus completion and read data
//   BUS_ERR                  timeout flag, pulsed together with READY
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    output logic        IF_READY,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    input  logic [2:0]  MEM_FUNC3,
    output logic [31:0] MEM_RDATA,
    output logic        MEM_READY,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [2:0]  BUS_FUNC3,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_RDATA,
    output logic        BUS_ERR
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);

    arb_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  bus_func3_q, bus_func3_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q,   bus_err_d;

    logic burst_full;
    logic grant_mem;
    logic grant_if;
    logic in_gnt;
    logic bus_expire;

    assign burst_full = (cnt_q == CNT_W'(MAX_DATA_BURST));
    assign grant_mem  = (state_q == ST_IDLE) && mem_wins(MEM_REQ, IF_REQ, burst_full);
    assign grant_if   = (state_q == ST_IDLE) && !grant_mem && IF_REQ;
    assign in_gnt     = (state_q == ST_GNT_IF) || (state_q == ST_GNT_MEM);

`ifdef ARB_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk    (CLK),
        .rst_n  (RST),
        .run    (in_gnt),
        .expire (bus_expire)
    );
`else
    assign bus_expire = 1'b0;

    // Keeps the timeout parameter referenced when the watchdog is not built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d = ST_GNT_MEM;
                end else if (grant_if) begin
                    state_d = ST_GNT_IF;
                end
            end
            ST_GNT_IF, ST_GNT_MEM: begin
                if (BUS_ACK || bus_expire) begin
                    state_d = ST_RESP;
                end
            end
            // REQ of the finished transaction is still high here, so no new
            // decision is taken until the FSM is back in IDLE.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_func3_d = bus_func3_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEM_WE;
                    bus_addr_d  = MEM_ADDR;
                    bus_wdata_d = MEM_WDATA;
                    bus_func3_d = MEM_FUNC3;
                    // Count only data grants that made a fetch wait.
                    if (IF_REQ) begin
                        cnt_d = burst_full ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else if (grant_if) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = IF_ADDR;
                    bus_wdata_d = '0;
                    bus_func3_d = FUNC3_LW;
                    cnt_d       = '0;
                end
            end
            ST_GNT_IF: begin
                if (BUS_ACK) begin
                    bus_req_d  = 1'b0;
                    if_rdata_d = BUS_RDATA;
                    if_ready_d = 1'b1;
                end else if (bus_expire) begin
                    bus_req_d  = 1'b0;
                    if_rdata_d = '0;
                    if_ready_d = 1'b1;
                    bus_err_d  = 1'b1;
                end
            end
            ST_GNT_MEM: begin
                if (BUS_ACK) begin
                    bus_req_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    // A store keeps the last load result visible.
                    if (!bus_we_q) begin
                        mem_rdata_d = BUS_RDATA;
                    end
                end else if (bus_expire) begin
                    bus_req_d   = 1'b0;
                    mem_rdata_d = '0;
                    mem_ready_d = 1'b1;
                    bus_err_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_func3_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_func3_q <= bus_func3_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign BUS_REQ   = bus_req_q;
    assign BUS_WE    = bus_we_q;
    assign BUS_ADDR  = bus_addr_q;
    assign BUS_WDATA = bus_wdata_q;
    assign BUS_FUNC3 = bus_func3_q;
    assign IF_RDATA  = if_rdata_q;
    assign IF_READY  = if_ready_q;
    assign MEM_RDATA = mem_rdata_q;
    assign MEM_READY = mem_ready_q;
    assign BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at that same point, before new inputs
//   are applied. Build with ARB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        IF_READY;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [2:0]  MEM_FUNC3;
    logic [31:0] MEM_RDATA;
    logic        MEM_READY;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic [2:0]  BUS_FUNC3;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        BUS_ERR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .MAX_DATA_BURST (4),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_RDATA  (IF_RDATA),
        .IF_READY  (IF_READY),
        .MEM_REQ   (MEM_REQ),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_FUNC3 (MEM_FUNC3),
        .MEM_RDATA (MEM_RDATA),
        .MEM_READY (MEM_READY),
        .BUS_REQ   (BUS_REQ),
        .BUS_WE    (BUS_WE),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WDATA (BUS_WDATA),
        .BUS_FUNC3 (BUS_FUNC3),
        .BUS_ACK   (BUS_ACK),
        .BUS_RDATA (BUS_RDATA),
        .BUS_ERR   (BUS_ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Expected grant order with both requesters held: M M M M I M M M M
    logic [8:0] exp_mem_grant = 9'b1_1110_1111; // bit i = grant i goes to MEM

    initial begin
        RST = 1'b0;
        IF_REQ = 1'b0; IF_ADDR = '0;
        MEM_REQ = 1'b0; MEM_WE = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0; MEM_FUNC3 = '0;
        BUS_ACK = 1'b0; BUS_RDATA = '0;

        // ---------------- reset
        tick();
        tick();
        check_eq("rst_bus_req",   {31'd0, BUS_REQ}, 32'd0);
        check_eq("rst_bus_addr",  BUS_ADDR, 32'd0);
        check_eq("rst_bus_func3", {29'd0, BUS_FUNC3}, 32'd0);
        check_eq("rst_readys",    {30'd0, IF_READY, MEM_READY}, 32'd0);
        check_eq("rst_rdata",     IF_RDATA | MEM_RDATA, 32'd0);
        check_eq("rst_bus_err",   {31'd0, BUS_ERR}, 32'd0);

        RST = 1'b1; IF_REQ = 1'b1; IF_ADDR = 32'h0;
        tick();                                   // IDLE decides for IF
        check_eq("fetch_bus_req",   {31'd0, BUS_REQ}, 32'd1);
        check_eq("fetch_bus_func3", {29'd0, BUS_FUNC3}, 32'd2);
        check_eq("fetch_bus_we",    {31'd0, BUS_WE}, 32'd0);

        // ---------------- single fetch, ACK in first bus cycle
        BUS_ACK = 1'b1; BUS_RDATA = 32'h00500093;
        tick();
        BUS_ACK = 1'b0;
        check_eq("fetch_if_ready",  {31'd0, IF_READY}, 32'd1);
        check_eq("fetch_if_rdata",  IF_RDATA, 32'h00500093);
        check_eq("fetch_mem_ready", {31'd0, MEM_READY}, 32'd0);
        check_eq("fetch_bus_drop",  {31'd0, BUS_REQ}, 32'd0);
        tick();                                   // RESP -> IDLE
        check_eq("fetch_ready_1cyc", {30'd0, IF_READY, MEM_READY}, 32'd0);
        IF_REQ = 1'b0;
        tick();
        check_eq("idle_no_req", {31'd0, BUS_REQ}, 32'd0);

        // ---------------- conflict: MEM first, then IF
        IF_REQ = 1'b1; IF_ADDR = 32'h40;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h100; MEM_FUNC3 = 3'b010;
        tick();
        check_eq("conf_first_addr", BUS_ADDR, 32'h100);
        for (int w = 0; w < 2; w++) begin
            tick();
            check_eq("conf_wait_held", {30'd0, BUS_REQ, IF_READY | MEM_READY}, 32'd2);
        end
        BUS_ACK = 1'b1; BUS_RDATA = 32'hCAFE0001;
        tick();
        BUS_ACK = 1'b0;
        check_eq("conf_mem_ready", {30'd0, MEM_READY, IF_READY}, 32'd2);
        check_eq("conf_mem_rdata", MEM_RDATA, 32'hCAFE0001);
        tick();
        MEM_REQ = 1'b0;
        tick();                                   // IDLE decides for pending IF
        check_eq("conf_second_addr",  BUS_ADDR, 32'h40);
        check_eq("conf_second_func3", {29'd0, BUS_FUNC3}, 32'd2);
        BUS_ACK = 1'b1; BUS_RDATA = 32'h11112222;
        tick();
        BUS_ACK = 1'b0;
        check_eq("conf_if_ready", {30'd0, MEM_READY, IF_READY}, 32'd1);
        check_eq("conf_if_rdata", IF_RDATA, 32'h11112222);
        tick();
        IF_REQ = 1'b0;
        tick();

        // ---------------- starvation limit
        IF_REQ = 1'b1; IF_ADDR = 32'h80;
        MEM_REQ = 1'b1; MEM_WE = 1'b0; MEM_ADDR = 32'h300;
        for (int i = 0; i < 9; i++) begin
            logic [31:0] exp_addr;
            exp_addr = exp_mem_grant[i] ? 32'h300 : 32'h80;
            tick();
            check_eq($sformatf("starve_grant%0d", i), BUS_ADDR, exp_addr);
            BUS_ACK = 1'b1; BUS_RDATA = 32'h50000000 + i;
            tick();
            BUS_ACK = 1'b0;
            check_eq($sformatf("starve_ready%0d", i), {30'd0, MEM_READY, IF_READY},
                     exp_mem_grant[i] ? 32'd2 : 32'd1);
            tick();
        end
        IF_REQ = 1'b0; MEM_REQ = 1'b0;
        tick();

        // ---------------- store keeps MEM_RDATA
        MEM_REQ = 1'b1; MEM_WE = 1'b1; MEM_ADDR = 32'h200; MEM_FUNC3 = 3'b000; MEM_WDATA = 32'hAB;
        tick();
        check_eq("st_bus_we",    {31'd0, BUS_WE}, 32'd1);
        check_eq("st_bus_addr",  BUS_ADDR, 32'h200);
        check_eq("st_bus_wdata", BUS_WDATA, 32'hAB);
        check_eq("st_bus_func3", {29'd0, BUS_FUNC3}, 32'd0);
        BUS_ACK = 1'b1; BUS_RDATA = 32'hDEADBEEF;
        tick();
        BUS_ACK = 1'b0;
        check_eq("st_mem_ready", {31'd0, MEM_READY}, 32'd1);
        check_eq("st_rdata_kept", MEM_RDATA, 32'h50000008);
        tick();
        MEM_REQ = 1'b0; MEM_WE = 1'b0;
        tick();

        // ---------------- reset in GNT_MEM with ACK in the same cycle
        MEM_REQ = 1'b1; MEM_ADDR = 32'h104; MEM_FUNC3 = 3'b010;
        tick();
        check_eq("rstg_bus_req", {31'd0, BUS_REQ}, 32'd1);
        BUS_ACK = 1'b1; BUS_RDATA = 32'h77777777; RST = 1'b0;
        tick();
        BUS_ACK = 1'b0; RST = 1'b1; MEM_REQ = 1'b0;
        check_eq("rstg_no_ready", {30'd0, MEM_READY, BUS_REQ}, 32'd0);
        check_eq("rstg_rdata",    MEM_RDATA, 32'd0);
        tick();
        check_eq("rstg_still_idle", {30'd0, MEM_READY, BUS_REQ}, 32'd0);

        // ---------------- plain load after reset
        MEM_REQ = 1'b1; MEM_ADDR = 32'h10C;
        tick();
        check_eq("ld_bus_addr", BUS_ADDR, 32'h10C);
        BUS_ACK = 1'b1; BUS_RDATA = 32'h00001234;
        tick();
        BUS_ACK = 1'b0;
        check_eq("ld_rdata", MEM_RDATA, 32'h00001234);
        check_eq("ld_no_err", {31'd0, BUS_ERR}, 32'd0);
        tick();
        MEM_REQ = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // ---------------- bus timeout: ACK never arrives
        begin
            int waited;
            waited = 0;
            MEM_REQ = 1'b1; MEM_ADDR = 32'h108;
            tick();
            while (!MEM_READY && waited < 40) begin
                tick();
                waited++;
            end
            check_eq("to_wait_cycles", waited, TO_CYC);
            check_eq("to_bus_err",     {30'd0, BUS_ERR, MEM_READY}, 32'd3);
            check_eq("to_rdata",       MEM_RDATA, 32'd0);
            check_eq("to_bus_drop",    {31'd0, BUS_REQ}, 32'd0);
            tick();
            MEM_REQ = 1'b0;
            check_eq("to_err_pulse",   {31'd0, BUS_ERR}, 32'd0);
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
